fetch_stage: RTL and testbench

Instruction fetch stage of the RISC-V pipeline core. Owns the program counter and computes the next-PC. Drives the address of the instruction memory, honours its `waitrequest`, and registers the returned instruction into the IF/ID pipeline register for decode. Handles hazard-unit stalls and flushes, and branch/jump redirects from Execute. A redirect that arrives while memory is stalled is held pending until the memory access completes.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_if.sv | 20 ++
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// The optional perf counters in fetch_stage are enabled by defining FETCH_PERF_EN.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StRun,
    StWait,
    StRedir
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory bus between the fetch stage (master) and the memory (slave).
interface fetch_if;

  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemWaitrequest;

  modport master (
    output ImemAddr,
    input  ImemRdata,
    input  ImemWaitrequest
  );

  modport slave (
    input  ImemAddr,
    output ImemRdata,
    output ImemWaitrequest
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority among the controls: flush (bubble) > stall (hold) > bubble request > load.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_stall,
  input  logic   i_flush,
  input  logic   i_bubble,
  input  if_id_t i_data,
  output if_id_t o_data
);

  localparam if_id_t Bubble = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  if_id_t r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= Bubble;
    end else if (i_flush) begin
      r_data <= Bubble;
    end else if (!i_stall) begin
      r_data <= i_bubble ? Bubble : i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC selection, imem waitrequest handling and IF/ID register.
// Define FETCH_PERF_EN to build the fetched-instruction and wait-cycle counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  fetch_if.master     imem,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] PerfFetched,
  output logic [31:0] PerfWaitCycles
);

  fetch_state_e r_state;
  logic [31:0]  r_pcf;
  logic [31:0]  r_pend_pc;

  logic         w_wait;
  logic         w_bubble;
  logic [31:0]  w_pcf_plus4;
  logic [31:0]  w_target;
  if_id_t       w_if_data;
  if_id_t       w_id_data;

  assign w_wait         = imem.ImemWaitrequest;
  assign w_pcf_plus4    = r_pcf + 32'd4;
  assign w_target       = align_pc(PCTargetE);
  assign imem.ImemAddr  = r_pcf;
  // In REDIR the in-flight word belongs to a dead path, so it never reaches decode.
  assign w_bubble       = w_wait || (r_state == StRedir);
  assign w_if_data      = '{instr: imem.ImemRdata, pc: r_pcf, pc_plus4: w_pcf_plus4,
                            valid: 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StRun;
      r_pcf     <= RESET_PC;
      r_pend_pc <= '0;
    end else begin
      unique case (r_state)
        StRun, StWait: begin
          if (w_wait) begin
            if (PCSrcE) begin
              r_pend_pc <= w_target;
              r_state   <= StRedir;
            end else begin
              r_state   <= StWait;
            end
          end else begin
            r_state <= StRun;
            if (PCSrcE) begin
              r_pcf <= w_target;
            end else if (!StallF) begin
              r_pcf <= w_pcf_plus4;
            end
          end
        end
        StRedir: begin
          if (w_wait) begin
            // Youngest redirect wins while the dead fetch drains.
            if (PCSrcE) begin
              r_pend_pc <= w_target;
            end
          end else begin
            r_state <= StRun;
            r_pcf   <= PCSrcE ? w_target : r_pend_pc;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .i_stall  (StallD),
    .i_flush  (FlushD),
    .i_bubble (w_bubble),
    .i_data   (w_if_data),
    .o_data   (w_id_data)
  );

  assign InstrD   = w_id_data.instr;
  assign PCD      = w_id_data.pc;
  assign PCPlus4D = w_id_data.pc_plus4;
  assign ValidD   = w_id_data.valid;

`ifdef FETCH_PERF_EN
  logic        w_load_valid;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_waits;

  assign w_load_valid = !FlushD && !StallD && !w_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_waits   <= '0;
    end else begin
      if (w_load_valid) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_wait) begin
        r_perf_waits <= r_perf_waits + 32'd1;
      end
    end
  end

  assign PerfFetched    = r_perf_fetched;
  assign PerfWaitCycles = r_perf_waits;
`else
  assign PerfFetched    = '0;
  assign PerfWaitCycles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected IF/ID contents are queued as stimulus is driven.
module tb_fetch_stage;
  import fetch_pkg::*;

`ifdef FETCH_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  typedef logic [96:0] exp_t;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [31:0] PerfFetched;
  logic [31:0] PerfWaitCycles;

  fetch_if u_if ();

  fetch_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem           (u_if.master),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD),
    .PerfFetched    (PerfFetched),
    .PerfWaitCycles (PerfWaitCycles)
  );

  int   n_tests;
  int   n_fail;
  int   exp_fetched;
  int   exp_waits;
  exp_t sb[$];
  exp_t exp_v;
  exp_t last_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  assign u_if.ImemRdata = mem_word(u_if.ImemAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_valid(input logic [31:0] pc);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    sb.push_back({mem_word(pc), pc, pc4, 1'b1});
    exp_fetched++;
  endtask

  task automatic push_bubble();
    sb.push_back({DEFAULT_NOP_INSTR, 32'h0, 32'h0, 1'b0});
  endtask

  function automatic exp_t id_now();
    return {InstrD, PCD, PCPlus4D, ValidD};
  endfunction

  task automatic test_reset();
    rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    u_if.ImemWaitrequest = 1'b0;
    #1;
    n_tests++;
    if (id_now() !== {DEFAULT_NOP_INSTR, 64'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_ifid got %h req bubble", id_now());
    end
    n_tests++;
    if ({PerfFetched, PerfWaitCycles} !== 64'h0) begin
      n_fail++; $display("FAIL reset_perf got %h/%h req 0/0", PerfFetched, PerfWaitCycles);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (u_if.ImemAddr !== DEFAULT_RESET_PC || ValidD !== 1'b0) begin
      n_fail++; $display("FAIL first_cycle got addr %h valid %b req %h 0",
                         u_if.ImemAddr, ValidD, DEFAULT_RESET_PC);
    end
  endtask

  task automatic test_free_run_and_stall();
    for (int i = 0; i < 2; i++) begin
      push_valid(32'(i * 4));
      tick();
      exp_v = sb.pop_front(); last_v = exp_v;
      n_tests++;
      if (id_now() !== exp_v) begin
        n_fail++; $display("FAIL free_run ifid got %h req %h", id_now(), exp_v);
      end
    end
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (u_if.ImemAddr !== 32'h8 || id_now() !== last_v) begin
        n_fail++; $display("FAIL stall_hold got addr %h ifid %h req 8 %h",
                           u_if.ImemAddr, id_now(), last_v);
      end
    end
    StallF = 1'b0; StallD = 1'b0;
    for (int i = 2; i < 4; i++) begin
      push_valid(32'(i * 4));
      tick();
      exp_v = sb.pop_front();
      n_tests++;
      if (id_now() !== exp_v || u_if.ImemAddr !== 32'(i * 4 + 4)) begin
        n_fail++; $display("FAIL resume ifid got %h addr %h req %h %h",
                           id_now(), u_if.ImemAddr, exp_v, 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_redirect();
    PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1;
    push_bubble();
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h100) begin
      n_fail++; $display("FAIL redirect_flush got %h addr %h req %h 100",
                         id_now(), u_if.ImemAddr, exp_v);
    end
    PCSrcE = 1'b0; FlushD = 1'b0;
    push_valid(32'h100);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h104) begin
      n_fail++; $display("FAIL redirect_fetch got %h addr %h req %h 104",
                         id_now(), u_if.ImemAddr, exp_v);
    end
  endtask

  task automatic test_wait();
    // Redirect without FlushD: the younger fetch still lands in decode.
    PCSrcE = 1'b1; PCTargetE = 32'h20;
    push_valid(32'h104);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h20) begin
      n_fail++; $display("FAIL no_squash got %h addr %h req %h 20", id_now(), u_if.ImemAddr, exp_v);
    end
    PCSrcE = 1'b0; u_if.ImemWaitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_bubble(); exp_waits++;
      tick();
      exp_v = sb.pop_front();
      n_tests++;
      if (id_now() !== exp_v || u_if.ImemAddr !== 32'h20) begin
        n_fail++; $display("FAIL wait_bubble got %h addr %h req %h 20",
                           id_now(), u_if.ImemAddr, exp_v);
      end
    end
    u_if.ImemWaitrequest = 1'b0;
    n_tests++;
    if (PerfWaitCycles !== (PerfOn ? 32'(exp_waits) : 32'h0) ||
        PerfFetched !== (PerfOn ? 32'(exp_fetched) : 32'h0)) begin
      n_fail++; $display("FAIL perf_wait got %0d/%0d req %0d/%0d", PerfFetched, PerfWaitCycles,
                         PerfOn ? exp_fetched : 0, PerfOn ? exp_waits : 0);
    end
    push_valid(32'h20);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h24) begin
      n_fail++; $display("FAIL wait_release got %h addr %h req %h 24",
                         id_now(), u_if.ImemAddr, exp_v);
    end
  endtask

  task automatic test_redir_pending();
    logic [31:0] targets[3];
    logic        pulses[3];
    targets = '{32'h200, 32'h300, 32'h0};
    pulses  = '{1'b1, 1'b1, 1'b0};
    PCSrcE = 1'b1; PCTargetE = 32'h20;
    push_valid(32'h24);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h20) begin
      n_fail++; $display("FAIL redir_setup got %h addr %h req %h 20", id_now(), u_if.ImemAddr, exp_v);
    end
    u_if.ImemWaitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PCSrcE = pulses[i]; PCTargetE = targets[i];
      push_bubble(); exp_waits++;
      tick();
      exp_v = sb.pop_front();
      n_tests++;
      if (id_now() !== exp_v || u_if.ImemAddr !== 32'h20) begin
        n_fail++; $display("FAIL redir_hold got %h addr %h req %h 20",
                           id_now(), u_if.ImemAddr, exp_v);
      end
    end
    PCSrcE = 1'b0; u_if.ImemWaitrequest = 1'b0;
    push_bubble();
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h300) begin
      n_fail++; $display("FAIL redir_exit got %h addr %h req %h 300",
                         id_now(), u_if.ImemAddr, exp_v);
    end
    push_valid(32'h300);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h304) begin
      n_fail++; $display("FAIL redir_fetch got %h addr %h req %h 304",
                         id_now(), u_if.ImemAddr, exp_v);
    end
  endtask

  task automatic test_reset_mid_redir();
    u_if.ImemWaitrequest = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h400;
    push_bubble();
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h304) begin
      n_fail++; $display("FAIL enter_redir got %h addr %h req %h 304",
                         id_now(), u_if.ImemAddr, exp_v);
    end
    PCSrcE = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (u_if.ImemAddr !== DEFAULT_RESET_PC || id_now() !== {DEFAULT_NOP_INSTR, 64'h0, 1'b0} ||
        {PerfFetched, PerfWaitCycles} !== 64'h0) begin
      n_fail++; $display("FAIL async_reset got addr %h ifid %h perf %h/%h req reset values",
                         u_if.ImemAddr, id_now(), PerfFetched, PerfWaitCycles);
    end
    u_if.ImemWaitrequest = 1'b0;
    tick();
    rst = 1'b0;
    exp_fetched = 0; exp_waits = 0;
    push_valid(DEFAULT_RESET_PC);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h4) begin
      n_fail++; $display("FAIL restart got %h addr %h req %h 4", id_now(), u_if.ImemAddr, exp_v);
    end
  endtask

  task automatic test_boundaries();
    PCSrcE = 1'b1; PCTargetE = 32'h203;
    push_valid(32'h4);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h200) begin
      n_fail++; $display("FAIL align_target got %h addr %h req %h 200",
                         id_now(), u_if.ImemAddr, exp_v);
    end
    PCTargetE = 32'hFFFF_FFFE;
    push_valid(32'h200);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL top_target got %h addr %h req %h fffffffc",
                         id_now(), u_if.ImemAddr, exp_v);
    end
    PCSrcE = 1'b0;
    push_valid(32'hFFFF_FFFC);
    tick();
    exp_v = sb.pop_front();
    n_tests++;
    if (id_now() !== exp_v || u_if.ImemAddr !== 32'h0) begin
      n_fail++; $display("FAIL pc_wrap got %h addr %h req %h 0", id_now(), u_if.ImemAddr, exp_v);
    end
    n_tests++;
    if (PerfFetched !== (PerfOn ? 32'(exp_fetched) : 32'h0) ||
        PerfWaitCycles !== (PerfOn ? 32'(exp_waits) : 32'h0)) begin
      n_fail++; $display("FAIL perf_final got %0d/%0d req %0d/%0d", PerfFetched, PerfWaitCycles,
                         PerfOn ? exp_fetched : 0, PerfOn ? exp_waits : 0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; exp_fetched = 0; exp_waits = 0;
    test_reset();
    test_free_run_and_stall();
    test_redirect();
    test_wait();
    test_redir_pending();
    test_reset_mid_redir();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
